mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory/write-back stage of the 5-stage CPU pipeline, sitting between the EX/MEM pipeline register and the register file. Non-memory results pass through in one cycle. Loads and stores run through a request/ready handshake with data memory, holding the pipeline with a stall until the access completes or times out. Outputs drive the register-file write port (`wb_wrEn`, `wb_rD`, `wb_ppp`, `wb_data`). These are also the signals the register file uses for its write-through bypass.

## Interface
- `TIMEOUT`, 255: max MEM_WAIT cycles before abort; legal range 1..255.
- `clk` in 1: pipeline clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low; 0 forces reset state immediately.
- `ex_valid` in 1: EX/MEM holds a valid instruction.
- `ex_wrEn` in 1: instruction writes `ex_rD`.
- `ex_is_load` in 1: load instruction (at most one of load/store set).
- `ex_is_store` in 1: store instruction.
- `ex_rD` in [0:4]: destination register.
- `ex_ppp` in [0:2]: participation field, passed unchanged to `wb_ppp`.
- `ex_alu` in [0:63]: ALU result, or effective address for load/store.
- `ex_st_data` in [0:63]: store data.
- `stall` out 1: combinational; 1 = upstream must hold EX/MEM contents.
- `dmem_en` out 1: memory request active.
- `dmem_wrEn` out 1: 1 = write, 0 = read.
- `dmem_addr` out [0:31]: word address, from `ex_alu[32:63]`.
- `dmem_dout` out [0:63]: store data to memory.
- `dmem_din` in [0:63]: load data from memory.
- `dmem_ready` in 1: access complete this cycle.
- `wb_wrEn` out 1: register-file write enable.
- `wb_rD` out [0:4]: register-file destination.
- `wb_ppp` out [0:2]: register-file participation field.
- `wb_data` out [0:63]: register-file write data.
- `mem_err` out 1: sticky timeout flag; cleared only by reset.

## Operation
- **States:** IDLE, MEM_WAIT.
- **Request register:** holds `rD`, `ppp`, `wrEn`, `is_load`, addr, store data.
- **Wait counter:** 8-bit.
- **IDLE, `ex_valid`=1, not load/store:**
  - Next edge: `wb_wrEn`←`ex_wrEn`, `wb_rD`←`ex_rD`, `wb_ppp`←`ex_ppp`, `wb_data`←`ex_alu`.
  - `stall`=0.
- **IDLE, `ex_valid`=0:** next edge `wb_wrEn`←0; other `wb_*` hold.
- **IDLE, `ex_valid`=1, load or store:**
  - `stall`=1 combinationally.
  - Capture request register; counter←0; next state MEM_WAIT; `wb_wrEn`←0 (bubble).
- **MEM_WAIT:**
  - `stall`=1 every cycle, including the completion cycle.
  - `dmem_en`=1.
  - `dmem_wrEn`, `dmem_addr`, `dmem_dout` driven from the request register and stable throughout.
  - `wb_wrEn`=0 until exit.
- **MEM_WAIT, `dmem_ready`=1:**
  - Load: `wb_wrEn`←req `wrEn`, `wb_rD`←req `rD`, `wb_ppp`←req `ppp`, `wb_data`←`dmem_din`.
  - Store: `wb_wrEn`←0.
  - Next state IDLE.
- **MEM_WAIT, `dmem_ready`=0, counter = `TIMEOUT`-1:** abort; `mem_err`←1, `wb_wrEn`←0, next state IDLE.
- **MEM_WAIT, otherwise:** counter←counter+1.
- **Boundary rules:**
  - `dmem_ready` in the same cycle as the timeout condition: ready wins, no error.
  - `dmem_ready` in IDLE: ignored.
  - EX inputs are ignored in MEM_WAIT. The held instruction is consumed in the first IDLE cycle after exit.
  - `ex_rD`=0 is passed through unchanged; register-file logic suppresses the write.
  - `ex_is_load` and `ex_is_store` both set: treated as a load.
- **Reset:**
  - `reset`=0 at any time, including mid-MEM_WAIT: state←IDLE, counter←0, `mem_err`←0.
  - All registered outputs ←0 (`wb_wrEn`, `wb_rD`, `wb_ppp`, `wb_data`, `dmem_en`, `dmem_wrEn`, `dmem_addr`, `dmem_dout`).
  - `stall` is 0 while in reset. The in-flight request is dropped.

## Timing
- **ALU op:** 1-cycle latency, EX input edge → `wb_*` valid; back-to-back throughput 1/cycle.
- **Memory op:** accept cycle (stall, bubble), then N MEM_WAIT cycles ending on the `dmem_ready` cycle. Load result is on `wb_*` the cycle after ready. The held instruction enters the cycle after that; total `stall` cycles = N+1.
- **Timeout:** `mem_err` rises on the edge ending the `TIMEOUT`-th MEM_WAIT cycle.
- **`dmem_en` timing:** registered, rises one cycle after the accept cycle, falls on the edge after ready or abort.
- **`wb_*` timing:** registered, valid for exactly one cycle per write.

## Test plan
- **Reset, then ALU op:**
  - Stimulus: reset low mid-sim, then ALU op `ex_rD`=5, `ex_ppp`=0, `ex_alu`=64'h0123456789ABCDEF, `ex_wrEn`=1.
  - Required: all outputs 0 during reset. Next cycle `wb_wrEn`=1, `wb_rD`=5, `wb_data`=64'h0123456789ABCDEF.
- **Load, `dmem_ready` after 3 wait cycles:**
  - Stimulus: `ex_alu`=64'h40, `ex_rD`=7, `ex_ppp`=3'b011, `dmem_din`=64'hFFFF0000AAAA5555.
  - Required: `stall`=1 for 4 cycles; `dmem_addr`=32'h40, `dmem_wrEn`=0.
  - Required: then `wb_wrEn`=1, `wb_rD`=7, `wb_ppp`=3'b011, `wb_data`=64'hFFFF0000AAAA5555.
- **Store, `dmem_ready` on first wait cycle:**
  - Stimulus: `ex_st_data`=64'hDEADBEEF00000000.
  - Required: `dmem_wrEn`=1, `dmem_dout`=64'hDEADBEEF00000000; `wb_wrEn` stays 0.
  - Required: following ALU op written one cycle after IDLE.
- **Timeout:**
  - Stimulus: `TIMEOUT`=4, load with `dmem_ready` never asserted.
  - Required: `mem_err`=1 after 4 MEM_WAIT cycles, `wb_wrEn`=0, return to IDLE, `mem_err` stays 1.
- **Ready coincident with timeout:** `TIMEOUT`=4, `dmem_ready`=1 on 4th wait cycle → load completes, `mem_err`=0.
- **Reset asserted in MEM_WAIT:** reset pulled low during MEM_WAIT → immediate IDLE, `dmem_en`=0, no write after reset release.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Data-memory port of the MEM/WB stage: request fields out, load data and
// completion handshake back.
interface mem_wb_stage_if;
    logic        dmem_en;
    logic        dmem_wrEn;
    logic [0:31] dmem_addr;
    logic [0:63] dmem_dout;
    logic [0:63] dmem_din;
    logic        dmem_ready;

    modport master (
        output dmem_en, dmem_wrEn, dmem_addr, dmem_dout,
        input  dmem_din, dmem_ready
    );

    modport slave (
        input  dmem_en, dmem_wrEn, dmem_addr, dmem_dout,
        output dmem_din, dmem_ready
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: ALU results pass straight to the register-file
// write port; loads and stores wait on the data-memory handshake with a
// bounded wait and a sticky timeout flag.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ex_valid,
    input  logic           ex_wrEn,
    input  logic           ex_is_load,
    input  logic           ex_is_store,
    input  logic [0:4]     ex_rD,
    input  logic [0:2]     ex_ppp,
    input  logic [0:63]    ex_alu,
    input  logic [0:63]    ex_st_data,
    output logic           stall,
    mem_wb_stage_if.master dmem,
    output logic           wb_wrEn,
    output logic [0:4]     wb_rD,
    output logic [0:2]     wb_ppp,
    output logic [0:63]    wb_data,
    output logic           mem_err
);

    typedef enum logic {
        IDLE,
        MEM_WAIT
    } state_t;

    // Counter value seen during the last permitted wait cycle.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       req_wrEn;
    logic       req_is_load;
    logic [0:4] req_rD;
    logic [0:2] req_ppp;
    logic       is_mem_op;
    logic       accept;
    logic       done;
    logic       abort;

    assign is_mem_op = ex_is_load | ex_is_store;

    // State register; reset drops any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, accept/complete/abort decode and the combinational stall.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid && is_mem_op) begin
                    accept     = 1'b1;
                    next_state = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dmem.dmem_ready) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else if (wait_cnt == LAST_WAIT) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        stall = reset && ((state == MEM_WAIT) || accept);
    end

    // Request capture, memory port, wait counter and write-back registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt       <= '0;
            req_wrEn       <= 1'b0;
            req_is_load    <= 1'b0;
            req_rD         <= '0;
            req_ppp        <= '0;
            mem_err        <= 1'b0;
            wb_wrEn        <= 1'b0;
            wb_rD          <= '0;
            wb_ppp         <= '0;
            wb_data        <= '0;
            dmem.dmem_en   <= 1'b0;
            dmem.dmem_wrEn <= 1'b0;
            dmem.dmem_addr <= '0;
            dmem.dmem_dout <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_wrEn       <= ex_wrEn;
                        req_is_load    <= ex_is_load;
                        req_rD         <= ex_rD;
                        req_ppp        <= ex_ppp;
                        wait_cnt       <= '0;
                        wb_wrEn        <= 1'b0;
                        dmem.dmem_en   <= 1'b1;
                        dmem.dmem_wrEn <= ~ex_is_load;
                        dmem.dmem_addr <= ex_alu[32:63];
                        dmem.dmem_dout <= ex_st_data;
                    end else if (ex_valid) begin
                        wb_wrEn <= ex_wrEn;
                        wb_rD   <= ex_rD;
                        wb_ppp  <= ex_ppp;
                        wb_data <= ex_alu;
                    end else begin
                        wb_wrEn <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    wb_wrEn <= 1'b0;
                    if (done) begin
                        dmem.dmem_en <= 1'b0;
                        if (req_is_load) begin
                            wb_wrEn <= req_wrEn;
                            wb_rD   <= req_rD;
                            wb_ppp  <= req_ppp;
                            wb_data <= dmem.dmem_din;
                        end
                    end else if (abort) begin
                        dmem.dmem_en <= 1'b0;
                        mem_err      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vectors, multi-cycle memory
// sequences and a randomized instruction stream against a transaction model.
module tb_mem_wb_stage;

    localparam int unsigned TO    = 4;
    localparam int          NPROG = 200;

    typedef struct {
        logic        valid;
        logic        wrEn;
        logic [0:4]  rD;
        logic [0:2]  ppp;
        logic [0:63] alu;
        logic        exp_wrEn;
        logic [0:4]  exp_rD;
        logic [0:2]  exp_ppp;
        logic [0:63] exp_data;
    } vec_t;

    typedef struct {
        logic        valid;
        logic        wrEn;
        logic        ld;
        logic        st;
        logic [0:4]  rD;
        logic [0:2]  ppp;
        logic [0:63] alu;
        logic [0:63] sd;
        logic [0:63] din;
        int          lat;
    } instr_t;

    typedef struct {
        logic [0:4]  rD;
        logic [0:2]  ppp;
        logic [0:63] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic        ex_wrEn;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [0:4]  ex_rD;
    logic [0:2]  ex_ppp;
    logic [0:63] ex_alu;
    logic [0:63] ex_st_data;
    logic        stall;
    logic        wb_wrEn;
    logic [0:4]  wb_rD;
    logic [0:2]  wb_ppp;
    logic [0:63] wb_data;
    logic        mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t   vecs[6];
    instr_t prog[$];
    wr_t    exp_q[$];
    instr_t t;
    wr_t    e;
    int     kind;
    int     idx;
    int     mem_idx;
    int     waitc;
    logic   exp_err;
    logic   drained;

    mem_wb_stage_if dmem_bus();

    mem_wb_stage #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_wrEn     (ex_wrEn),
        .ex_is_load  (ex_is_load),
        .ex_is_store (ex_is_store),
        .ex_rD       (ex_rD),
        .ex_ppp      (ex_ppp),
        .ex_alu      (ex_alu),
        .ex_st_data  (ex_st_data),
        .stall       (stall),
        .dmem        (dmem_bus),
        .wb_wrEn     (wb_wrEn),
        .wb_rD       (wb_rD),
        .wb_ppp      (wb_ppp),
        .wb_data     (wb_data),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic wr, input logic ld, input logic st,
                                 input logic [0:4] rd, input logic [0:2] ppp,
                                 input logic [0:63] alu, input logic [0:63] sd);
        ex_valid    = valid;
        ex_wrEn     = wr;
        ex_is_load  = ld;
        ex_is_store = st;
        ex_rD       = rd;
        ex_ppp      = ppp;
        ex_alu      = alu;
        ex_st_data  = sd;
    endtask

    task automatic apply_idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 64'd0, 64'd0);
    endtask

    task automatic set_mem(input logic rdy, input logic [0:63] din);
        dmem_bus.dmem_ready = rdy;
        dmem_bus.dmem_din   = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string name, input logic we, input logic [0:4] rd,
                            input logic [0:2] ppp, input logic [0:63] data);
        checkOutput({name, ".wb_wrEn"}, 64'(wb_wrEn), 64'(we));
        checkOutput({name, ".wb_rD"},   64'(wb_rD),   64'(rd));
        checkOutput({name, ".wb_ppp"},  64'(wb_ppp),  64'(ppp));
        checkOutput({name, ".wb_data"}, wb_data,      data);
    endtask

    task automatic check_all_zero(input string name);
        check_wb(name, 1'b0, 5'd0, 3'd0, 64'd0);
        checkOutput({name, ".dmem_en"},   64'(dmem_bus.dmem_en),   64'd0);
        checkOutput({name, ".dmem_wrEn"}, 64'(dmem_bus.dmem_wrEn), 64'd0);
        checkOutput({name, ".dmem_addr"}, 64'(dmem_bus.dmem_addr), 64'd0);
        checkOutput({name, ".dmem_dout"}, dmem_bus.dmem_dout,      64'd0);
        checkOutput({name, ".stall"},     64'(stall),              64'd0);
        checkOutput({name, ".mem_err"},   64'(mem_err),            64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 5'd1,  3'd7, 64'h1111, 1'b1, 5'd1,  3'd7, 64'h1111};
        vecs[1] = '{1'b1, 1'b0, 5'd2,  3'd1, 64'h2222, 1'b0, 5'd2,  3'd1, 64'h2222};
        vecs[2] = '{1'b0, 1'b1, 5'd3,  3'd2, 64'h3333, 1'b0, 5'd2,  3'd1, 64'h2222};
        vecs[3] = '{1'b1, 1'b1, 5'd0,  3'd4, 64'h4444, 1'b1, 5'd0,  3'd4, 64'h4444};
        vecs[4] = '{1'b1, 1'b1, 5'd31, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{1'b0, 1'b0, 5'd6,  3'd6, 64'h6666, 1'b0, 5'd31, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF};

        // Power-up reset with a load presented and ready high: nothing may move.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd8, 3'd1, 64'h40, 64'd0);
        set_mem(1'b1, '1);
        #2 reset = 1'b0;
        tick();
        check_all_zero("por");
        apply_idle();
        set_mem(1'b0, 64'd0);
        reset = 1'b1;

        // Reset pulled low mid-simulation after a write.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 3'd2, 64'hAAAA, 64'd0);
        tick();
        check_wb("pre_rst", 1'b1, 5'd9, 3'd2, 64'hAAAA);
        reset = 1'b0;
        #1;
        check_all_zero("mid_rst");
        tick();
        check_all_zero("rst_held");
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 3'd0, 64'h0123456789ABCDEF, 64'd0);
        #1 checkOutput("alu.stall", 64'(stall), 64'd0);
        tick();
        check_wb("alu_after_rst", 1'b1, 5'd5, 3'd0, 64'h0123456789ABCDEF);

        // Back-to-back ALU / bubble vectors.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].wrEn, 1'b0, 1'b0, vecs[i].rD, vecs[i].ppp, vecs[i].alu, 64'd0);
            #1 checkOutput($sformatf("vec%0d.stall", i), 64'(stall), 64'd0);
            tick();
            check_wb($sformatf("vec%0d", i), vecs[i].exp_wrEn, vecs[i].exp_rD, vecs[i].exp_ppp, vecs[i].exp_data);
        end

        // Load completing on the third wait cycle; next ALU op held meanwhile.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 3'b011, 64'h40, 64'h5555);
        set_mem(1'b0, 64'hFFFF0000AAAA5555);
        #1 checkOutput("ld.accept_stall", 64'(stall), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 3'd6, 64'h9999, 64'd0);
        for (int w = 1; w <= 3; w++) begin
            set_mem(1'(w == 3), 64'hFFFF0000AAAA5555);
            #1;
            checkOutput($sformatf("ld.w%0d.stall", w),   64'(stall),              64'd1);
            checkOutput($sformatf("ld.w%0d.en", w),      64'(dmem_bus.dmem_en),   64'd1);
            checkOutput($sformatf("ld.w%0d.addr", w),    64'(dmem_bus.dmem_addr), 64'h40);
            checkOutput($sformatf("ld.w%0d.wrEn", w),    64'(dmem_bus.dmem_wrEn), 64'd0);
            checkOutput($sformatf("ld.w%0d.wb_wrEn", w), 64'(wb_wrEn),            64'd0);
            tick();
        end
        set_mem(1'b0, 64'd0);
        check_wb("ld.result", 1'b1, 5'd7, 3'b011, 64'hFFFF0000AAAA5555);
        checkOutput("ld.en_off", 64'(dmem_bus.dmem_en), 64'd0);
        #1 checkOutput("ld.next_stall", 64'(stall), 64'd0);
        tick();
        check_wb("ld.next_alu", 1'b1, 5'd9, 3'd6, 64'h9999);

        // Store completing on the first wait cycle.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 3'd1, 64'h80, 64'hDEADBEEF00000000);
        #1 checkOutput("st.accept_stall", 64'(stall), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 3'd2, 64'h4444, 64'd0);
        set_mem(1'b1, 64'h1234);
        #1;
        checkOutput("st.stall",   64'(stall),              64'd1);
        checkOutput("st.en",      64'(dmem_bus.dmem_en),   64'd1);
        checkOutput("st.wrEn",    64'(dmem_bus.dmem_wrEn), 64'd1);
        checkOutput("st.addr",    64'(dmem_bus.dmem_addr), 64'h80);
        checkOutput("st.dout",    dmem_bus.dmem_dout,      64'hDEADBEEF00000000);
        checkOutput("st.wb_wrEn", 64'(wb_wrEn),            64'd0);
        tick();
        set_mem(1'b0, 64'd0);
        checkOutput("st.exit_wb_wrEn", 64'(wb_wrEn),          64'd0);
        checkOutput("st.en_off",       64'(dmem_bus.dmem_en), 64'd0);
        #1 checkOutput("st.next_stall", 64'(stall), 64'd0);
        tick();
        check_wb("st.next_alu", 1'b1, 5'd4, 3'd2, 64'h4444);

        // Load that never sees ready: abort after TO wait cycles.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd10, 3'd0, 64'h100, 64'd0);
        #1 checkOutput("to.accept_stall", 64'(stall), 64'd1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd11, 3'd3, 64'hBBBB, 64'd0);
        for (int w = 1; w <= int'(TO); w++) begin
            #1;
            checkOutput($sformatf("to.w%0d.stall", w),   64'(stall),            64'd1);
            checkOutput($sformatf("to.w%0d.en", w),      64'(dmem_bus.dmem_en), 64'd1);
            checkOutput($sformatf("to.w%0d.mem_err", w), 64'(mem_err),          64'd0);
            tick();
        end
        checkOutput("to.mem_err", 64'(mem_err),          64'd1);
        checkOutput("to.wb_wrEn", 64'(wb_wrEn),          64'd0);
        checkOutput("to.en_off",  64'(dmem_bus.dmem_en), 64'd0);
        #1 checkOutput("to.next_stall", 64'(stall), 64'd0);
        tick();
        check_wb("to.next_alu", 1'b1, 5'd11, 3'd3, 64'hBBBB);
        checkOutput("to.err_sticky1", 64'(mem_err), 64'd1);
        apply_idle();
        tick();
        checkOutput("to.err_sticky2", 64'(mem_err), 64'd1);

        // Reset asserted mid-wait: request dropped, flag cleared, no late write.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 3'd2, 64'h200, 64'd0);
        tick();
        apply_idle();
        tick();
        checkOutput("rw.en_before", 64'(dmem_bus.dmem_en), 64'd1);
        reset = 1'b0;
        #1;
        check_all_zero("rw.in_reset");
        set_mem(1'b1, 64'hEEEE);
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("rw.c%0d.wb_wrEn", c), 64'(wb_wrEn),          64'd0);
            checkOutput($sformatf("rw.c%0d.en", c),      64'(dmem_bus.dmem_en), 64'd0);
        end
        set_mem(1'b0, 64'd0);

        // Ready arriving on the very cycle the timeout would fire.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'd13, 3'd5, 64'h300, 64'd0);
        tick();
        apply_idle();
        for (int w = 1; w <= int'(TO); w++) begin
            set_mem(1'(w == int'(TO)), 64'hC0C0C0C0_12345678);
            tick();
        end
        set_mem(1'b0, 64'd0);
        check_wb("co.result", 1'b1, 5'd13, 3'd5, 64'hC0C0C0C0_12345678);
        checkOutput("co.mem_err", 64'(mem_err), 64'd0);

        // Load and store both set behaves as a load; ready in the accept cycle is ignored.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd14, 3'd7, 64'h400, 64'h5A5A);
        set_mem(1'b1, 64'h0F0F_0F0F_0F0F_0F0F);
        tick();
        apply_idle();
        checkOutput("both.wrEn",    64'(dmem_bus.dmem_wrEn), 64'd0);
        checkOutput("both.en",      64'(dmem_bus.dmem_en),   64'd1);
        checkOutput("both.wb_wrEn", 64'(wb_wrEn),            64'd0);
        tick();
        set_mem(1'b0, 64'd0);
        check_wb("both.result", 1'b1, 5'd14, 3'd7, 64'h0F0F_0F0F_0F0F_0F0F);

        // Randomized instruction stream against a transaction-level model.
        reset = 1'b0;
        #1 reset = 1'b1;
        exp_err = 1'b0;
        for (int i = 0; i < NPROG; i++) begin
            kind    = $urandom_range(0, 9);
            t.valid = (kind != 5);
            t.wrEn  = ($urandom_range(0, 3) != 0);
            t.ld    = (kind == 6) || (kind == 7) || (kind == 9);
            t.st    = (kind == 8) || (kind == 9);
            t.rD    = 5'($urandom);
            t.ppp   = 3'($urandom);
            t.alu   = {$urandom, $urandom};
            t.sd    = {$urandom, $urandom};
            t.din   = {$urandom, $urandom};
            t.lat   = $urandom_range(1, 6);
            prog.push_back(t);
            if (t.valid) begin
                if (t.ld || t.st) begin
                    if (t.lat > int'(TO)) begin
                        exp_err = 1'b1;
                    end else if (t.ld && t.wrEn) begin
                        exp_q.push_back('{t.rD, t.ppp, t.din});
                    end
                end else if (t.wrEn) begin
                    exp_q.push_back('{t.rD, t.ppp, t.alu});
                end
            end
        end

        idx     = 0;
        mem_idx = 0;
        waitc   = 0;
        drained = 1'b0;
        tick();
        for (int cyc = 0; cyc < NPROG * 12; cyc++) begin
            if (wb_wrEn) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rnd.unexpected_write", 64'(wb_wrEn), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rnd.wb_rD",   64'(wb_rD),  64'(e.rD));
                    checkOutput("rnd.wb_ppp",  64'(wb_ppp), 64'(e.ppp));
                    checkOutput("rnd.wb_data", wb_data,     e.data);
                end
            end
            if (idx == NPROG && !dmem_bus.dmem_en) begin
                drained = 1'b1;
                break;
            end
            if (dmem_bus.dmem_en) begin
                waitc++;
                if (waitc == 1) begin
                    checkOutput("rnd.addr", 64'(dmem_bus.dmem_addr), 64'(prog[mem_idx].alu[32:63]));
                    checkOutput("rnd.wrEn", 64'(dmem_bus.dmem_wrEn), 64'(!prog[mem_idx].ld));
                    checkOutput("rnd.dout", dmem_bus.dmem_dout,      prog[mem_idx].sd);
                end
                set_mem(1'(waitc == prog[mem_idx].lat), prog[mem_idx].din);
            end else begin
                waitc = 0;
                set_mem(1'($urandom_range(0, 1)), {$urandom, $urandom});
            end
            if (idx < NPROG) begin
                applyStimulus(prog[idx].valid, prog[idx].wrEn, prog[idx].ld, prog[idx].st,
                              prog[idx].rD, prog[idx].ppp, prog[idx].alu, prog[idx].sd);
            end else begin
                apply_idle();
            end
            #1;
            checkOutput("rnd.stall", 64'(stall),
                        64'(dmem_bus.dmem_en || (ex_valid && (ex_is_load || ex_is_store))));
            if (!dmem_bus.dmem_en && idx < NPROG) begin
                if (prog[idx].valid && (prog[idx].ld || prog[idx].st)) begin
                    mem_idx = idx;
                end
                idx++;
            end
            tick();
        end
        checkOutput("rnd.drained",        64'(drained),      64'd1);
        checkOutput("rnd.pending_writes", 64'(exp_q.size()), 64'd0);
        checkOutput("rnd.mem_err",        64'(mem_err),      64'(exp_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
